// File: rtl/muldiv_iter_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// M-op funct3 codes, FSM state encoding and operand-sign helpers.
package muldiv_iter_pkg;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
// Multiply: radix-2 shift-add; divide: restoring shift-subtract.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic [XLEN:0]     rem,
    output logic [2*XLEN-1:0] acc_nx,
    output logic [XLEN-1:0]   a_nx,
    output logic [XLEN:0]     rem_nx
);

    logic [XLEN:0]   sum;
    logic [XLEN+1:0] r_sh;
    logic            ge;

    // Single step: add multiplicand into the high half, or trial-subtract the divisor
    always_comb begin
        acc_nx = acc;
        a_nx   = a;
        rem_nx = rem;
        sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, a};
        r_sh   = {rem, a[XLEN-1]};
        ge     = r_sh >= {2'b00, b};
        if (div) begin
            a_nx   = {a[XLEN-2:0], ge};
            rem_nx = ge ? (XLEN+1)'(r_sh - {2'b00, b}) : r_sh[XLEN:0];
        end else if (acc[0]) begin
            acc_nx = {sum, acc[XLEN-1:1]};
        end else begin
            acc_nx = {1'b0, acc[2*XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// FSM IDLE->PREP->CALC(XLEN)->FIX->DONE with kill/hold handshake.
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CW   = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            kill,
    input  logic            hold,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    state_t            state, nxt;
    logic [2:0]        f3;
    logic [XLEN-1:0]   a_r, b_r;
    logic [2*XLEN-1:0] acc;
    logic [XLEN:0]     rem;
    logic [CW-1:0]     cnt;
    logic              neg_q, neg_r;

    logic              sa, sb, dz, ovf;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] acc_nx, prod;
    logic [XLEN-1:0]   a_nx, quo, rmd, fix_res;
    logic [XLEN:0]     rem_nx;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .div    (f3[2]),
        .acc    (acc),
        .a      (a_r),
        .b      (b_r),
        .rem    (rem),
        .acc_nx (acc_nx),
        .a_nx   (a_nx),
        .rem_nx (rem_nx)
    );

    // Operand sign/magnitude, special divide cases and final sign-corrected result
    always_comb begin
        sa    = a_is_signed(f3) && a_r[XLEN-1];
        sb    = b_is_signed(f3) && b_r[XLEN-1];
        mag_a = sa ? -a_r : a_r;
        mag_b = sb ? -b_r : b_r;
        dz    = f3[2] && (b_r == '0);
        ovf   = ((f3 == F3_DIV) || (f3 == F3_REM)) &&
                (a_r == {1'b1, {(XLEN-1){1'b0}}}) && (b_r == '1);
        prod  = neg_q ? -acc : acc;
        quo   = neg_q ? -a_r : a_r;
        rmd   = neg_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];
        unique case (f3)
            F3_MUL:                      fix_res = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             fix_res = quo;
            default:                     fix_res = rmd;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    // Next-state logic; kill overrides every transition
    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: if (start) nxt = S_PREP;
            S_PREP: nxt = (dz || ovf) ? S_DONE : S_CALC;
            S_CALC: if (cnt == CW'(XLEN-1)) nxt = S_FIX;
            S_FIX:  nxt = S_DONE;
            S_DONE: if (!hold) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
        if (kill) nxt = S_IDLE;
    end

    // Operand latch, iteration registers and result; frozen on kill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f3     <= '0;
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            rem    <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else if (!kill) begin
            unique case (state)
                S_IDLE: if (start) begin
                    f3     <= funct3;
                    a_r    <= op_a;
                    b_r    <= op_b;
                    rd_out <= rd_in;
                end
                S_PREP: begin
                    a_r   <= mag_a;
                    b_r   <= mag_b;
                    neg_q <= sa ^ sb;
                    neg_r <= sa;
                    acc   <= {{XLEN{1'b0}}, mag_b};
                    rem   <= '0;
                    cnt   <= '0;
                    if (dz)       result <= f3[1] ? a_r : '1;
                    else if (ovf) result <= f3[1] ? '0 : a_r;
                end
                S_CALC: begin
                    a_r <= a_nx;
                    acc <= acc_nx;
                    rem <= rem_nx;
                    cnt <= cnt + 1'b1;
                end
                S_FIX: result <= fix_res;
                default: ;
            endcase
        end
    end

    assign busy  = (state == S_PREP) || (state == S_CALC) || (state == S_FIX);
    assign valid = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: vector table, random ops against
// a behavioural model, and kill/hold/reset sequences.
module tb_muldiv_iter;
    import muldiv_iter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  rd_in = '0;
    logic        kill = 1'b0;
    logic        hold = 1'b0;
    logic        busy, valid;
    logic [31:0] result;
    logic [4:0]  rd_out;

    muldiv_iter #(.XLEN(32), .CW(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .kill   (kill),
        .hold   (hold),
        .busy   (busy),
        .valid  (valid),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] xa, xb, ub;
        logic [63:0] p;
        logic ov;
        xa = {{32{a[31]}}, a};
        xb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p  = '0;
        case (f3)
            F3_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            F3_MULH:   begin p = xa * xb; return p[63:32]; end
            F3_MULHSU: begin p = xa * ub; return p[63:32]; end
            F3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            F3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ov) return a;
                return 32'($signed(a) / $signed(b));
            end
            F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM: begin
                if (b == 0) return a;
                if (ov) return 32'h0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b);
        if (f3[2] && (b == 0)) return 1;
        if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
        return 34;
    endfunction

    task automatic drive(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp);
        exp_t e;
        e.res = exp;
        e.rd  = rd;
        e.lat = lat_of(f3, a, b);
        sb.push_back(e);
        drive(f3, a, b, rd);
    endtask

    task automatic wait_result(input string tag);
        int   edges = 0;
        int   bcnt = 0;
        exp_t e;
        while (!valid && edges < 100) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            edges++;
        end
        if (sb.size() == 0) begin
            chk({tag, " scoreboard"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, " latency"}, 64'(edges), 64'(e.lat));
            chk({tag, " busy_cycles"}, 64'(bcnt), 64'(e.lat));
            chk({tag, " result"}, 64'(result), 64'(e.res));
            chk({tag, " rd_out"}, 64'(rd_out), 64'(e.rd));
        end
    endtask

    task automatic finish_op(input string tag);
        @(posedge clk);
        #1;
        chk({tag, " valid_drop"}, 64'(valid), 64'd0);
        chk({tag, " busy_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2]  = '{F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
        vecs[4]  = '{F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{F3_DIVU,   32'd100,       32'd7,         32'd14};
        vecs[7]  = '{F3_REMU,   32'd100,       32'd7,         32'd2};
        vecs[8]  = '{F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{F3_REM,    32'd5,         32'd0,         32'd5};
        vecs[10] = '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset valid", 64'(valid), 64'd0);
        chk("reset result", 64'(result), 64'd0);
        chk("reset rd_out", 64'(rd_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp);
            wait_result($sformatf("vec%0d", i));
            finish_op($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 12; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            issue(f3, a, b, 5'(i + 13), model(f3, a, b));
            wait_result($sformatf("rnd%0d", i));
            finish_op($sformatf("rnd%0d", i));
        end

        // kill in the tenth CALC cycle
        begin
            logic saw;
            saw = 1'b0;
            drive(F3_DIVU, 32'd1000, 32'd3, 5'd20);
            repeat (10) @(posedge clk);
            @(negedge clk);
            kill = 1'b1;
            @(posedge clk);
            #1;
            kill = 1'b0;
            chk("kill busy", 64'(busy), 64'd0);
            chk("kill valid", 64'(valid), 64'd0);
            repeat (40) begin
                @(posedge clk);
                #1;
                if (valid || busy) saw = 1'b1;
            end
            chk("kill no_valid", 64'(saw), 64'd0);
            issue(F3_DIVU, 32'd100, 32'd7, 5'd9, 32'd14);
            wait_result("after_kill");
            finish_op("after_kill");
        end

        // kill together with start in IDLE
        begin
            logic saw;
            saw = 1'b0;
            @(negedge clk);
            funct3 = F3_MUL;
            op_a   = 32'd3;
            op_b   = 32'd4;
            rd_in  = 5'd7;
            start  = 1'b1;
            kill   = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            kill  = 1'b0;
            chk("kill_start busy", 64'(busy), 64'd0);
            repeat (5) begin
                @(posedge clk);
                #1;
                if (valid || busy) saw = 1'b1;
            end
            chk("kill_start idle", 64'(saw), 64'd0);
            chk("kill_start rd_out", 64'(rd_out), 64'd9);
        end

        // hold in DONE for 3 cycles, start ignored meanwhile
        issue(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFE);
        wait_result("hold");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            hold  = 1'b1;
            start = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d valid", i), 64'(valid), 64'd1);
            chk($sformatf("hold%0d result", i), 64'(result), 64'hFFFF_FFFE);
            chk($sformatf("hold%0d busy", i), 64'(busy), 64'd0);
        end
        @(negedge clk);
        hold  = 1'b0;
        start = 1'b0;
        finish_op("hold");

        // asynchronous reset in the middle of CALC
        drive(F3_MUL, 32'd7, 32'd9, 5'd5);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst valid", 64'(valid), 64'd0);
        chk("rst result", 64'(result), 64'd0);
        chk("rst rd_out", 64'(rd_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst busy", 64'(busy), 64'd0);

        issue(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd30, 32'hFFFF_FFEB);
        wait_result("recover");
        finish_op("recover");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
